// File: rtl/axi4_hp_slave_mem.sv
// rtl/axi4_hp_slave_mem.sv - AXI4 burst slave over on-chip 64-bit memory; optional macro ADDR_RANGE_CHECK_EN
module axi4_hp_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk_100Mhz,
  input  logic        rst,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [7:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic [63:0] WDATA,
  input  logic [7:0]  WSTRB,
  input  logic        WVALID,
  input  logic        WLAST,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  output logic        RLAST,
  input  logic        RREADY,
  output logic [31:0] wr_beats_total,
  output logic [31:0] rd_beats_total
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [2:0] SIZE_64     = 3'b011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Storage is never reset so frame data survives a bus reset.
  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] mem_rd_q;

  logic             ready_en_q;
  logic [1:0]       w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d;
  logic [7:0]       w_cnt_q, w_cnt_d;
  logic             w_fixed_q, w_fixed_d;
  logic             w_err_q, w_err_d;
  logic             w_supp_q, w_supp_d;
  logic [31:0]      wr_total_q, wr_total_d;

  logic [1:0]       r_state_q, r_state_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [7:0]       r_len_q, r_len_d;
  logic [7:0]       r_cnt_q, r_cnt_d;
  logic             r_fixed_q, r_fixed_d;
  logic             r_err_q, r_err_d;
  logic [31:0]      rd_total_q, rd_total_d;
  logic             r_load;

  logic [31:0] aw_off, ar_off;
  logic        aw_oor, ar_oor;
  logic        w_last_beat, r_last_beat;
  logic        mem_we;
  logic        unused_addr;

  assign aw_off = AWADDR - BASE_ADDR;
  assign ar_off = ARADDR - BASE_ADDR;
`ifdef ADDR_RANGE_CHECK_EN
  assign aw_oor = |aw_off[31:IDX_W+3];
  assign ar_oor = |ar_off[31:IDX_W+3];
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif
  // Low byte-offset bits (and high bits when wrapping) are intentionally dropped.
  assign unused_addr = ^{aw_off, ar_off};

  assign AWREADY = ready_en_q && (w_state_q == W_IDLE);
  assign WREADY  = (w_state_q == W_DATA);
  assign BVALID  = (w_state_q == W_RESP);
  assign BRESP   = (BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign ARREADY = ready_en_q && (r_state_q == R_IDLE);
  assign RVALID  = (r_state_q == R_DATA);
  assign RLAST   = RVALID && r_last_beat;
  assign RRESP   = (RVALID && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign RDATA   = (RVALID && !r_err_q) ? mem_rd_q : 64'd0;
  assign wr_beats_total = wr_total_q;
  assign rd_beats_total = rd_total_q;

  assign w_last_beat = (w_cnt_q == w_len_q);
  assign r_last_beat = (r_cnt_q == r_len_q);
  assign mem_we      = WREADY && WVALID && !w_supp_q;

  // Write channel next-state: address latch, beat accounting, error tracking.
  always_comb begin
    w_state_d  = w_state_q;
    w_idx_d    = w_idx_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    w_fixed_d  = w_fixed_q;
    w_err_d    = w_err_q;
    w_supp_d   = w_supp_q;
    wr_total_d = wr_total_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && AWREADY) begin
          w_idx_d   = aw_off[IDX_W+2:3];
          w_len_d   = AWLEN;
          w_fixed_d = (AWBURST == 2'b00);
          w_cnt_d   = 8'd0;
          w_supp_d  = (AWSIZE != SIZE_64) || aw_oor;
          w_err_d   = w_supp_d;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID) begin
          wr_total_d = wr_total_q + 32'd1;
          w_cnt_d    = w_cnt_q + 8'd1;
          if (!w_fixed_q) w_idx_d = w_idx_q + IDX_W'(1);
          if (WLAST != w_last_beat) w_err_d = 1'b1;
          if (w_last_beat) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel next-state: r_idx_q always points at the next word to fetch.
  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    r_fixed_d  = r_fixed_q;
    r_err_d    = r_err_q;
    rd_total_d = rd_total_q;
    r_load     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && ARREADY) begin
          r_idx_d   = ar_off[IDX_W+2:3];
          r_len_d   = ARLEN;
          r_fixed_d = (ARBURST == 2'b00);
          r_cnt_d   = 8'd0;
          r_err_d   = (ARSIZE != SIZE_64) || ar_oor;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        r_load    = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (RREADY) begin
          rd_total_d = rd_total_q + 32'd1;
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load && !r_fixed_q) r_idx_d = r_idx_q + IDX_W'(1);
  end

  // Control registers; ready_en_q holds AWREADY/ARREADY low until the first edge after reset.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      w_idx_q    <= '0;
      w_len_q    <= 8'd0;
      w_cnt_q    <= 8'd0;
      w_fixed_q  <= 1'b0;
      w_err_q    <= 1'b0;
      w_supp_q   <= 1'b0;
      wr_total_q <= 32'd0;
      r_state_q  <= R_IDLE;
      r_idx_q    <= '0;
      r_len_q    <= 8'd0;
      r_cnt_q    <= 8'd0;
      r_fixed_q  <= 1'b0;
      r_err_q    <= 1'b0;
      rd_total_q <= 32'd0;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      w_idx_q    <= w_idx_d;
      w_len_q    <= w_len_d;
      w_cnt_q    <= w_cnt_d;
      w_fixed_q  <= w_fixed_d;
      w_err_q    <= w_err_d;
      w_supp_q   <= w_supp_d;
      wr_total_q <= wr_total_d;
      r_state_q  <= r_state_d;
      r_idx_q    <= r_idx_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
      r_fixed_q  <= r_fixed_d;
      r_err_q    <= r_err_d;
      rd_total_q <= rd_total_d;
    end
  end

  // RAM port: byte-lane writes and a registered read that sees pre-write data on collision.
  always_ff @(posedge clk_100Mhz) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (WSTRB[b]) mem_q[w_idx_q][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
    if (r_load) mem_rd_q <= mem_q[r_idx_q];
  end

endmodule

// File: doc/axi4_hp_slave_mem.md
Name: axi4_hp_slave_mem

Overview:
- AXI4 slave responder with on-chip 64-bit memory.
- Sits at the far end of the frame writer/reader masters, in place of the Zynq HP0/HP1 ports, for closed-loop simulation and PL-only frame buffering.
- Accepts INCR/FIXED write bursts, stores them with byte strobes, and serves read bursts back.
- Write and read channels run independently, with one outstanding transaction each.

Parameters:
- BASE_ADDR, 32'h0100_0000: byte address mapped to memory word 0.
- DEPTH_WORDS, 4096: number of 64-bit words; must be a power of 2.
- IDX_W, $clog2(DEPTH_WORDS): word index width.

Ports:
- clk_100Mhz  in  1  AXI clock.
- rst  in  1  reset: asynchronous, active-high.
- AWADDR  in  32  write burst start byte address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWLEN  in  8  beats minus 1.
- AWSIZE  in  3  beat size; only 3'b011 is legal.
- AWBURST  in  2  00 = FIXED, 01 = INCR, 10 = treated as INCR.
- WDATA  in  64  write data.
- WSTRB  in  8  byte enables.
- WVALID  in  1  write data valid.
- WLAST  in  1  last write beat.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  32  read burst start byte address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARLEN  in  8  beats minus 1.
- ARSIZE  in  3  beat size.
- ARBURST  in  2  burst type, same rules as AWBURST.
- RDATA  out  64  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RLAST  out  1  last read beat.
- RREADY  in  1  read data ready.
- wr_beats_total  out  32  count of accepted W beats (debug).
- rd_beats_total  out  32  count of accepted R beats (debug).

Behaviour:
- Reset (async assert):
  - Write and read FSMs go to IDLE.
  - All outputs are 0, including AWREADY, ARREADY, RDATA and both totals.
  - Memory contents are retained, not cleared.
  - AWREADY/ARREADY go 1 on the first clk_100Mhz edge after rst deasserts.
  - Reset mid-burst aborts the burst: no BVALID is issued, and RVALID drops.
- Index computation: idx = (ADDR - BASE_ADDR) >> 3, truncated to IDX_W bits (wraps modulo DEPTH_WORDS). Address bits [2:0] are ignored.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY, latch idx, AWLEN and burst type; clear beat_cnt and the error flag; go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1.
    - Each W handshake writes byte lanes where WSTRB[i]=1, increments wr_beats_total and beat_cnt, and increments idx unless the burst is FIXED.
    - On the beat where beat_cnt==len, go to W_RESP.
    - Set the error flag if WLAST != (beat_cnt==len) on any beat, or if AWSIZE != 3'b011 (writes suppressed for illegal size).
  - W_RESP: BVALID=1 in the cycle after the last W handshake (latency 1). BRESP = 2'b10 (SLVERR) if the error flag is set, else 2'b00. On BREADY, go to W_IDLE.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: ARREADY=1. On handshake, latch idx/len/burst; go to R_FETCH.
  - R_FETCH: one-cycle synchronous RAM read.
  - R_DATA:
    - RVALID=1 with registered RDATA, so the first RVALID comes 2 cycles after the AR handshake.
    - RLAST=1 when beat_cnt==len.
    - RDATA, RRESP and RLAST stay stable while RVALID=1 and RREADY=0.
    - On an R handshake that is not last: present the next word in the next cycle (prefetch), so beats are back-to-back when RREADY is held high.
    - On the last handshake: RVALID=0 next cycle, go to R_IDLE.
  - ARSIZE != 3 gives RRESP=SLVERR on all beats, RDATA=0.
- Same-cycle write and read to the same word: read-first, the old data is returned.
- Counters wrap at 2^32. Beat counters are 8 bits, and a 256-beat burst (len=255) is supported.

Optional Feature:
- Macro: ADDR_RANGE_CHECK_EN.
- Defined:
  - A burst whose start address lies outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS) is still fully handshaken.
  - Such a write burst has its writes suppressed and gets BRESP=SLVERR.
  - Such a read burst returns RDATA=0 with RRESP=SLVERR on every beat.
- Not defined: addresses are wrapped modulo the memory size and always get OKAY, except for the WLAST/size errors above.

Test Plan:
- Write 16 beats (AWADDR=0x0100_0000, AWLEN=15, data=beat number, WSTRB=FF, WVALID always high), then read the same range with RREADY always high:
  - WREADY accepts 1 beat/cycle.
  - BVALID 1 cycle after the last beat, BRESP=00.
  - RVALID 2 cycles after AR, then 16 back-to-back beats with data 0..15 and RLAST on beat 15.
  - wr_beats_total=16, rd_beats_total=16.
- Write 0xFFFF_FFFF_FFFF_FFFF to word 4, then a 1-beat write of 0 with WSTRB=0x0F to word 4; read word 4 -> 0xFFFF_FFFF_0000_0000.
- 4-beat write with WLAST asserted on beat 2: all 4 beats accepted, BRESP=10. Hold BREADY=0 for 5 cycles -> BVALID held high and BRESP stable.
- Read 8 beats while toggling RREADY every cycle -> RDATA/RLAST stable while stalled, exactly 8 beats delivered, no duplicates.
- Assert rst mid-write at beat 3 of 8:
  - All outputs 0 immediately; AWREADY=1 on the first edge after release.
  - No BVALID issued.
  - Beats 0-2 persist in memory.
- With ADDR_RANGE_CHECK_EN, AWADDR=0x0200_0000, 2 beats: BRESP=10, memory unchanged; a read of the same address gives RDATA=0 and RRESP=10 on both beats.
